dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
- Sequences data-memory loads and stores issued from the MEM stage onto a valid/ready data-memory bus.
- Holds the pipeline via `stall_o` while a multi-cycle access is outstanding. `stall_o` drives the enable of the MEM/WB pipeline registers and the upstream registers.
- Aligns store data, generates byte strobes, extracts and sign/zero-extends load data.
- Flags misaligned accesses, bus errors and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent in REQ+RSP before the access is aborted with an error.
- CNT_W, 8: timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- pc_valid_i  in  1  MEM-stage instruction valid.
- mem_rd_en_i  in  1  load request.
- mem_wr_en_i  in  1  store request.
- mem_ctrl_i  in  4  [1:0] size (00 byte, 01 half, 10 word, 11 illegal → treated as misaligned); [2] unsigned load; [3] ignored.
- addr_i  in  32  effective address (ALU result).
- wdata_i  in  32  store source (rs2 data).
- flush_i  in  1  kill the MEM-stage instruction.
- stall_o  out  1  high = hold pipeline registers (en=0).
- dmem_req_o  out  1  bus request valid.
- dmem_we_o  out  1  1 = write.
- dmem_addr_o  out  32  word address, addr_i with [1:0] forced to 00.
- dmem_wstrb_o  out  4  byte-lane strobes.
- dmem_wdata_o  out  32  lane-replicated store data.
- dmem_ready_i  in  1  bus accepts request.
- dmem_rvalid_i  in  1  response valid (read data or write ack).
- dmem_rdata_i  in  32  read data.
- dmem_err_i  in  1  bus error, qualified by dmem_rvalid_i.
- load_data_o  out  32  aligned, extended load result.
- load_valid_o  out  1  one-cycle pulse with load_data_o.
- misalign_o  out  1  one-cycle pulse: misaligned access detected.
- bus_err_o  out  1  one-cycle pulse: bus error or timeout.

Behaviour:
- **access** = pc_valid_i & (mem_rd_en_i | mem_wr_en_i) & ~flush_i. If both rd and wr are set, it is a store.
- **misaligned** = (half & addr_i[0]) | (word & addr_i[1:0]≠0) | size==11.
- **FSM states:** IDLE, REQ, RSP, DONE.
- **IDLE:**
  - access & ~misaligned → latch addr, we, size, unsigned flag, lane-aligned wdata and wstrb; go to REQ; stall_o=1 this cycle.
  - access & misaligned → misalign_o=1 for this cycle; stall_o=0; no bus activity; stay in IDLE.
- **REQ:**
  - dmem_req_o=1, address/data/strobes held stable.
  - dmem_ready_i → RSP.
  - flush_i before handshake → IDLE with no pulses.
- **RSP:**
  - dmem_req_o=0.
  - dmem_rvalid_i → DONE, capturing rdata and err.
  - flush_i here does not abort; it only suppresses the DONE pulses.
  - dmem_rvalid_i is never sampled in the REQ cycle.
- **DONE:**
  - stall_o=0.
  - load_valid_o=1 only if load & ~err & ~flushed.
  - bus_err_o=1 if err & ~flushed.
  - Always → IDLE next cycle. Because DONE does not re-sample access, the same instruction cannot re-trigger.
- **stall_o** = (IDLE & access & ~misaligned) | REQ | RSP.
- **Minimum latency:** 4 cycles (IDLE→REQ→RSP→DONE), i.e. 3 stall cycles, when ready arrives in the first REQ cycle and rvalid in the first RSP cycle.
- **Timeout:**
  - Counter clears on entry to REQ and increments each REQ/RSP cycle.
  - On reaching TIMEOUT_CYCLES → DONE with err=1.
  - A late rvalid arriving after the timeout is ignored in IDLE.
- **Store lanes:**
  - byte: wdata={4{b}}, wstrb=0001<<addr[1:0].
  - half: {2{h}}, wstrb=0011<<addr[1:0].
  - word: 1111.
  - Loads drive wstrb=0000.
- **Load extract:**
  - byte lane = addr[1:0]; half lane = addr[1].
  - Sign-extend unless the unsigned flag is set.
  - load_data_o holds its value until the next load completes.
- **Reset:**
  - Takes priority over everything and aborts any access mid-flight.
  - After reset: state=IDLE; all outputs 0, including load_data_o, dmem_addr_o and dmem_wdata_o; counter=0.

Test Plan:
- **LW, zero-wait:** addr=0x100, ready in the first REQ cycle, rvalid next cycle, rdata=0xDEADBEEF → stall_o high for 3 cycles; DONE: load_valid_o=1, load_data_o=0xDEADBEEF; req held exactly 1 cycle.
- **LB signed and LBU:** addr=0x103, rdata=0x80FF_1234:
  - mem_ctrl=0000 → load_data_o=0xFFFFFF80.
  - mem_ctrl=0100 → 0x00000080.
- **SH with waits:** addr=0x202, wdata=0x0000ABCD, ready withheld 3 cycles → dmem_wdata_o=0xABCDABCD, wstrb=1100, addr=0x200; req/addr stable while waiting; load_valid_o never pulses.
- **Misaligned LW:** addr=0x101 → misalign_o one-cycle pulse, stall_o=0, dmem_req_o stays 0.
- **Timeout and error:**
  - TIMEOUT_CYCLES=4, ready never asserted → DONE after 4 REQ cycles, bus_err_o pulse, stall_o drops.
  - Separately, rvalid with dmem_err_i=1 → bus_err_o=1, load_valid_o=0.
- **Flush and reset mid-access:**
  - flush_i in REQ → IDLE, no pulses.
  - flush_i in RSP → waits for rvalid, then no load_valid_o.
  - rst in RSP → next cycle IDLE with all outputs 0.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: sequences MEM-stage loads/stores onto a valid/ready
// data-memory bus, holds the pipeline while an access is outstanding,
// lane-aligns store data, extracts/extends load data and reports
// misaligned accesses, bus errors and timeouts.
module dmem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_valid_i,
    input  logic        mem_rd_en_i,
    input  logic        mem_wr_en_i,
    input  logic [3:0]  mem_ctrl_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_wstrb_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ready_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i,
    input  logic        dmem_err_i,
    output logic [31:0] load_data_o,
    output logic        load_valid_o,
    output logic        misalign_o,
    output logic        bus_err_o
);

    typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_t;

    // Abort once the access has spent this many REQ+RSP cycles waiting.
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [29:0]       addr_q, addr_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [1:0]        lane_q, lane_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              flushed_q, flushed_d;
    logic [31:0]       load_data_q, load_data_d;

    logic        access;
    logic        misaligned;
    logic [31:0] lane_wdata;
    logic [3:0]  lane_wstrb;
    logic [31:0] ext_data;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        unused_ctrl;

    // Bit 3 of the control field carries no meaning for this block.
    assign unused_ctrl = mem_ctrl_i[3];

    assign access     = pc_valid_i & (mem_rd_en_i | mem_wr_en_i) & ~flush_i;
    assign misaligned = (mem_ctrl_i[1:0] == 2'b11)
                      | ((mem_ctrl_i[1:0] == 2'b01) & addr_i[0])
                      | ((mem_ctrl_i[1:0] == 2'b10) & (addr_i[1:0] != 2'b00));

    // Replicate store data across lanes and build strobes; loads write nothing.
    always_comb begin
        lane_wdata = wdata_i;
        lane_wstrb = 4'b1111;
        case (mem_ctrl_i[1:0])
            2'b00: begin
                lane_wdata = {4{wdata_i[7:0]}};
                lane_wstrb = 4'b0001 << addr_i[1:0];
            end
            2'b01: begin
                lane_wdata = {2{wdata_i[15:0]}};
                lane_wstrb = 4'b0011 << addr_i[1:0];
            end
            default: ;
        endcase
        if (!mem_wr_en_i) begin
            lane_wstrb = 4'b0000;
        end
    end

    // Pick the addressed byte/half of the returned word and extend it.
    always_comb begin
        case (lane_q)
            2'd0:    byte_sel = dmem_rdata_i[7:0];
            2'd1:    byte_sel = dmem_rdata_i[15:8];
            2'd2:    byte_sel = dmem_rdata_i[23:16];
            default: byte_sel = dmem_rdata_i[31:24];
        endcase
        half_sel = lane_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        case (size_q)
            2'b00:   ext_data = {{24{~uns_q & byte_sel[7]}}, byte_sel};
            2'b01:   ext_data = {{16{~uns_q & half_sel[15]}}, half_sel};
            default: ext_data = dmem_rdata_i;
        endcase
    end

    // Next-state and pulse logic; a flush after the handshake only
    // suppresses the completion pulses, it never abandons the bus.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        we_d         = we_q;
        size_d       = size_q;
        uns_d        = uns_q;
        lane_d       = lane_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        flushed_d    = flushed_q;
        load_data_d  = load_data_q;
        stall_o      = 1'b0;
        misalign_o   = 1'b0;
        load_valid_o = 1'b0;
        bus_err_o    = 1'b0;
        case (state_q)
            IDLE: begin
                if (access) begin
                    if (misaligned) begin
                        misalign_o = 1'b1;
                    end else begin
                        stall_o   = 1'b1;
                        addr_d    = addr_i[31:2];
                        we_d      = mem_wr_en_i;
                        size_d    = mem_ctrl_i[1:0];
                        uns_d     = mem_ctrl_i[2];
                        lane_d    = addr_i[1:0];
                        wdata_d   = lane_wdata;
                        wstrb_d   = lane_wstrb;
                        cnt_d     = '0;
                        err_d     = 1'b0;
                        flushed_d = 1'b0;
                        state_d   = REQ;
                    end
                end
            end
            REQ: begin
                stall_o = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (dmem_ready_i) begin
                    if (flush_i) begin
                        flushed_d = 1'b1;
                    end
                    state_d = RSP;
                end else if (flush_i) begin
                    state_d = IDLE;
                end else if (cnt_q >= TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            RSP: begin
                stall_o = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (flush_i) begin
                    flushed_d = 1'b1;
                end
                if (dmem_rvalid_i) begin
                    err_d   = dmem_err_i;
                    state_d = DONE;
                    if (!we_q && !dmem_err_i && !flushed_q && !flush_i) begin
                        load_data_d = ext_data;
                    end
                end else if (cnt_q >= TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                load_valid_o = ~we_q & ~err_q & ~flushed_q;
                bus_err_o    = err_q & ~flushed_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and latched access registers; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            we_q        <= 1'b0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            lane_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            flushed_q   <= 1'b0;
            load_data_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            lane_q      <= lane_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            flushed_q   <= flushed_d;
            load_data_q <= load_data_d;
        end
    end

    assign dmem_req_o   = (state_q == REQ);
    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = {addr_q, 2'b00};
    assign dmem_wstrb_o = wstrb_q;
    assign dmem_wdata_o = wdata_q;
    assign load_data_o  = load_data_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: table vectors, hand-written corner sequences and
// randomized transactions checked against a transaction-level model.
module tb_dmem_access_ctrl;

    localparam int TMO = 4;

    logic        clk;
    logic        rst;
    logic        pc_valid_i;
    logic        mem_rd_en_i;
    logic        mem_wr_en_i;
    logic [3:0]  mem_ctrl_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        flush_i;
    logic        stall_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_wstrb_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_ready_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        dmem_err_i;
    logic [31:0] load_data_o;
    logic        load_valid_o;
    logic        misalign_o;
    logic        bus_err_o;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [3:0]  ctrl;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        logic        mis;
        logic [31:0] e_addr;
        logic [3:0]  e_strb;
        logic [31:0] e_wdata;
        logic        lv;
        logic [31:0] ld;
        logic        berr;
    } vec_t;

    int          checks;
    int          errors;
    logic [31:0] last_ld;
    vec_t        tbl [12];

    dmem_access_ctrl #(.TIMEOUT_CYCLES(TMO), .CNT_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_valid_i    (pc_valid_i),
        .mem_rd_en_i   (mem_rd_en_i),
        .mem_wr_en_i   (mem_wr_en_i),
        .mem_ctrl_i    (mem_ctrl_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .flush_i       (flush_i),
        .stall_o       (stall_o),
        .dmem_req_o    (dmem_req_o),
        .dmem_we_o     (dmem_we_o),
        .dmem_addr_o   (dmem_addr_o),
        .dmem_wstrb_o  (dmem_wstrb_o),
        .dmem_wdata_o  (dmem_wdata_o),
        .dmem_ready_i  (dmem_ready_i),
        .dmem_rvalid_i (dmem_rvalid_i),
        .dmem_rdata_i  (dmem_rdata_i),
        .dmem_err_i    (dmem_err_i),
        .load_data_o   (load_data_o),
        .load_valid_o  (load_valid_o),
        .misalign_o    (misalign_o),
        .bus_err_o     (bus_err_o)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic driveIdle();
        pc_valid_i    = 1'b0;
        mem_rd_en_i   = 1'b0;
        mem_wr_en_i   = 1'b0;
        mem_ctrl_i    = 4'b0000;
        addr_i        = 32'h0;
        wdata_i       = 32'h0;
        flush_i       = 1'b0;
        dmem_ready_i  = 1'b0;
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = 32'h0;
        dmem_err_i    = 1'b0;
    endtask

    // Cycle budget: the access aborts in the first waiting cycle numbered at
    // or beyond TMO in which the awaited handshake does not arrive.
    task automatic modelTiming(input int dr, input int dv, output int n, output int req_n, output bit tmo);
        int t_r, t_v, first;
        t_r = dr + 1;
        if (t_r > TMO) begin
            n = TMO; req_n = TMO; tmo = 1'b1;
        end else begin
            req_n = t_r;
            first = (t_r + 1 > TMO) ? t_r + 1 : TMO;
            t_v   = t_r + dv + 1;
            if (t_v <= first) begin
                n = t_v; tmo = 1'b0;
            end else begin
                n = first; tmo = 1'b1;
            end
        end
    endtask

    function automatic logic modelMis(input logic [3:0] ctrl, input logic [31:0] addr);
        int sz = int'(ctrl[1:0]);
        return (sz == 3) || (sz == 1 && addr % 2 != 0) || (sz == 2 && addr % 4 != 0);
    endfunction

    function automatic logic [31:0] modelLoad(input logic [3:0] ctrl, input logic [31:0] addr, input logic [31:0] rd);
        logic [31:0] v;
        int sz = int'(ctrl[1:0]);
        if (sz == 0) begin
            v = (rd >> (8 * (addr % 4))) & 32'hFF;
            if (!ctrl[2] && v >= 128) v = v - 32'd256;
        end else if (sz == 1) begin
            v = (rd >> (16 * ((addr % 4) / 2))) & 32'hFFFF;
            if (!ctrl[2] && v >= 32768) v = v - 32'd65536;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    // Runs one access over a fixed cycle window with ready/rvalid scheduled
    // dr/dv cycles late, checking every cycle's outputs against the model.
    task automatic applyStimulus(input vec_t v, input int dr, input int dv, input int flush_at, input string tag);
        int n, req_n, t_r, t_v, win;
        bit tmo, acc, lv, berr;
        logic [31:0] ld;
        acc = v.rd | v.wr;
        t_r = dr + 1;
        t_v = dr + dv + 2;
        if (!acc || v.mis) begin
            n = -1; req_n = 0; tmo = 1'b0;
        end else begin
            modelTiming(dr, dv, n, req_n, tmo);
        end
        lv   = v.lv & ~tmo;
        berr = v.berr | tmo;
        if (n < 0) begin
            lv = 1'b0; berr = 1'b0;
        end
        if (flush_at > 0) begin
            lv = 1'b0; berr = 1'b0;
            if (flush_at < t_r && flush_at <= req_n) begin
                n = flush_at; req_n = flush_at;
            end
        end
        ld  = lv ? v.ld : last_ld;
        win = ((n + 1 > t_v) ? n + 1 : t_v) + 2;
        for (int k = 0; k < win; k++) begin
            pc_valid_i    = (k == 0);
            mem_rd_en_i   = v.rd;
            mem_wr_en_i   = v.wr;
            mem_ctrl_i    = v.ctrl;
            addr_i        = v.addr;
            wdata_i       = v.wdata;
            flush_i       = (flush_at > 0 && k == flush_at);
            dmem_ready_i  = (k == t_r);
            dmem_rvalid_i = (k == t_v);
            dmem_rdata_i  = (k == t_v) ? v.rdata : ~v.rdata;
            dmem_err_i    = (k == t_v) ? v.err : 1'b1;
            @(negedge clk);
            checkOutput($sformatf("%s k=%0d stall", tag, k), {31'd0, stall_o}, {31'd0, (k <= n)});
            checkOutput($sformatf("%s k=%0d req", tag, k), {31'd0, dmem_req_o}, {31'd0, (k >= 1 && k <= req_n)});
            checkOutput($sformatf("%s k=%0d misalign", tag, k), {31'd0, misalign_o}, {31'd0, (v.mis && acc && k == 0)});
            checkOutput($sformatf("%s k=%0d load_valid", tag, k), {31'd0, load_valid_o}, {31'd0, (lv && k == n + 1)});
            checkOutput($sformatf("%s k=%0d bus_err", tag, k), {31'd0, bus_err_o}, {31'd0, (berr && k == n + 1)});
            if (n >= 0 && k == n + 1) begin
                checkOutput($sformatf("%s load_data", tag), load_data_o, ld);
            end
            if (k >= 1 && k <= req_n) begin
                checkOutput($sformatf("%s k=%0d addr", tag, k), dmem_addr_o, v.e_addr);
                checkOutput($sformatf("%s k=%0d wstrb", tag, k), {28'd0, dmem_wstrb_o}, {28'd0, v.e_strb});
                checkOutput($sformatf("%s k=%0d we", tag, k), {31'd0, dmem_we_o}, {31'd0, v.wr});
                if (v.wr) begin
                    checkOutput($sformatf("%s k=%0d wdata", tag, k), dmem_wdata_o, v.e_wdata);
                end
            end
            @(posedge clk);
            #1;
        end
        last_ld = ld;
        driveIdle();
    endtask

    // Build a fully predicted random vector from the model rules.
    function automatic vec_t randVec();
        vec_t v;
        int   sz;
        v.rd    = 1'($urandom_range(0, 1));
        v.wr    = 1'($urandom_range(0, 1));
        v.ctrl  = 4'($urandom_range(0, 15));
        v.addr  = $urandom;
        v.wdata = $urandom;
        v.rdata = $urandom;
        v.err   = ($urandom_range(0, 7) == 0);
        sz      = int'(v.ctrl[1:0]);
        v.mis   = modelMis(v.ctrl, v.addr);
        v.e_addr = v.addr - (v.addr % 4);
        if (sz == 0) begin
            v.e_wdata = (v.wdata & 32'hFF) * 32'h01010101;
            v.e_strb  = 4'b0001 << (v.addr % 4);
        end else if (sz == 1) begin
            v.e_wdata = (v.wdata & 32'hFFFF) * 32'h00010001;
            v.e_strb  = 4'b0011 << (v.addr % 4);
        end else begin
            v.e_wdata = v.wdata;
            v.e_strb  = 4'b1111;
        end
        if (!v.wr) v.e_strb = 4'b0000;
        v.lv   = !v.wr && !v.err;
        v.ld   = modelLoad(v.ctrl, v.addr, v.rdata);
        v.berr = v.err;
        return v;
    endfunction

    initial begin
        vec_t v;
        checks  = 0;
        errors  = 0;
        last_ld = 32'h0;

        //             rd    wr    ctrl     addr          wdata         rdata         err   mis   e_addr        e_strb   e_wdata       lv    ld            berr
        tbl[0]  = '{1'b1, 1'b0, 4'b0010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,        1'b1, 32'hDEAD_BEEF, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 4'b0000, 32'h0000_0103, 32'h0,        32'h80FF_1234, 1'b0, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,        1'b1, 32'hFFFF_FF80, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 4'b0100, 32'h0000_0103, 32'h0,        32'h80FF_1234, 1'b0, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,        1'b1, 32'h0000_0080, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 4'b0001, 32'h0000_0102, 32'h0,        32'h80FF_1234, 1'b0, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,        1'b1, 32'hFFFF_80FF, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 4'b0101, 32'h0000_0100, 32'h0,        32'h80FF_1234, 1'b0, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,        1'b1, 32'h0000_1234, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 4'b0000, 32'h0000_0301, 32'h1234_5678, 32'h0,        1'b0, 1'b0, 32'h0000_0300, 4'b0010, 32'h7878_7878, 1'b0, 32'h0,        1'b0};
        tbl[6]  = '{1'b1, 1'b1, 4'b0010, 32'h0000_0404, 32'hCAFE_F00D, 32'h0,        1'b0, 1'b0, 32'h0000_0404, 4'b1111, 32'hCAFE_F00D, 1'b0, 32'h0,        1'b0};
        tbl[7]  = '{1'b1, 1'b0, 4'b0010, 32'h0000_0101, 32'h0,        32'h0,        1'b0, 1'b1, 32'h0,        4'b0000, 32'h0,        1'b0, 32'h0,        1'b0};
        tbl[8]  = '{1'b0, 1'b1, 4'b0001, 32'h0000_0203, 32'h0,        32'h0,        1'b0, 1'b1, 32'h0,        4'b0000, 32'h0,        1'b0, 32'h0,        1'b0};
        tbl[9]  = '{1'b1, 1'b0, 4'b0011, 32'h0000_0000, 32'h0,        32'h0,        1'b0, 1'b1, 32'h0,        4'b0000, 32'h0,        1'b0, 32'h0,        1'b0};
        tbl[10] = '{1'b1, 1'b0, 4'b0010, 32'h0000_0500, 32'h0,        32'h1111_1111, 1'b1, 1'b0, 32'h0000_0500, 4'b0000, 32'h0,        1'b0, 32'h0,        1'b1};
        tbl[11] = '{1'b1, 1'b0, 4'b1000, 32'h0000_0101, 32'h0,        32'h0000_7F00, 1'b0, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,        1'b1, 32'h0000_007F, 1'b0};

        driveIdle();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("reset stall", {31'd0, stall_o}, 32'd0);
        checkOutput("reset req", {31'd0, dmem_req_o}, 32'd0);
        checkOutput("reset addr", dmem_addr_o, 32'd0);
        checkOutput("reset wdata", dmem_wdata_o, 32'd0);
        checkOutput("reset load_data", load_data_o, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        $display("[TB] table vectors");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(tbl[i], 0, 0, 0, $sformatf("vec%0d", i));
        end

        $display("[TB] SH with ready withheld 3 cycles");
        v = '{1'b0, 1'b1, 4'b0001, 32'h0000_0202, 32'h0000_ABCD, 32'h0, 1'b0, 1'b0,
              32'h0000_0200, 4'b1100, 32'hABCD_ABCD, 1'b0, 32'h0, 1'b0};
        applyStimulus(v, 3, 0, 0, "sh_wait");

        $display("[TB] timeout with ready never in window");
        v = '{1'b1, 1'b0, 4'b0010, 32'h0000_0700, 32'h0, 32'h5555_5555, 1'b0, 1'b0,
              32'h0000_0700, 4'b0000, 32'h0, 1'b0, 32'h0, 1'b1};
        applyStimulus(v, 20, 0, 0, "timeout");

        $display("[TB] flush in REQ and flush in RSP");
        v = '{1'b1, 1'b0, 4'b0010, 32'h0000_0800, 32'h0, 32'h1357_9BDF, 1'b0, 1'b0,
              32'h0000_0800, 4'b0000, 32'h0, 1'b1, 32'h1357_9BDF, 1'b0};
        applyStimulus(v, 3, 0, 2, "flush_req");
        applyStimulus(v, 0, 2, 2, "flush_rsp");

        $display("[TB] reset during RSP");
        pc_valid_i = 1'b1; mem_rd_en_i = 1'b1; mem_ctrl_i = 4'b0010; addr_i = 32'h0000_0600;
        @(posedge clk); #1;
        pc_valid_i = 1'b0; dmem_ready_i = 1'b1;
        @(posedge clk); #1;
        dmem_ready_i = 1'b0; rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_rsp stall before", {31'd0, stall_o}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h2468_ACE0;
        @(negedge clk);
        checkOutput("rst_rsp stall", {31'd0, stall_o}, 32'd0);
        checkOutput("rst_rsp req", {31'd0, dmem_req_o}, 32'd0);
        checkOutput("rst_rsp we", {31'd0, dmem_we_o}, 32'd0);
        checkOutput("rst_rsp addr", dmem_addr_o, 32'd0);
        checkOutput("rst_rsp wstrb", {28'd0, dmem_wstrb_o}, 32'd0);
        checkOutput("rst_rsp wdata", dmem_wdata_o, 32'd0);
        checkOutput("rst_rsp load_data", load_data_o, 32'd0);
        checkOutput("rst_rsp pulses", {29'd0, load_valid_o, misalign_o, bus_err_o}, 32'd0);
        @(posedge clk); #1;
        dmem_rvalid_i = 1'b0;
        @(negedge clk);
        checkOutput("rst_rsp late rvalid", {30'd0, load_valid_o, stall_o}, 32'd0);
        last_ld = 32'h0;
        @(posedge clk); #1;
        driveIdle();

        $display("[TB] randomized transactions");
        for (int i = 0; i < 150; i++) begin
            v = randVec();
            applyStimulus(v, $urandom_range(0, 5), $urandom_range(0, 3), 0, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
